// File: rtl/mmc_spi_pkg.sv
// Shared constants for the MMC/SD SPI master engine.
// FSM encodings, fill byte and chip-select width helper.
package mmc_spi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_END   = 3'd4;

  localparam logic [7:0] FILL_BYTE = 8'hFF;

  function automatic int CS_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmc_spi_engine_clkgen.sv
// SPI half-period timer: one strobe every div+1 enabled cycles,
// alternating leading/trailing; restarts whenever enable drops.
module spi_clkgen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             lead,
  output logic             trail
);

  logic [DIV_W-1:0] cnt;
  logic             phase;
  logic             tick;

  assign tick  = en && (cnt == div);
  assign lead  = tick && !phase;
  assign trail = tick && phase;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/mmc_spi_engine.sv
// Multi-byte SPI master for SD/MMC cards: runtime divider,
// all four SPI modes, streamed tx/rx, optional CS hold.
module mmc_spi_engine
  import mmc_spi_pkg::*;
#(
  parameter int NCS   = 2,
  parameter int DIV_W = 16,
  parameter int LEN_W = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic [DIV_W-1:0]      div,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [CS_W(NCS)-1:0]  cs_sel,
  input  logic                  hold_cs,
  input  logic                  fill,
  input  logic [7:0]            tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NCS-1:0]        cs_n
);

  logic [2:0]       state;
  logic [LEN_W-1:0] bytes_left;
  logic [DIV_W-1:0] div_r;
  logic             cpol_r;
  logic             cpha_r;
  logic             hold_r;
  logic             fill_r;
  logic [7:0]       tx_sh;
  logic [6:0]       rx_sh;
  logic [3:0]       edge_cnt;

  logic             clk_en;
  logic             lead;
  logic             trail;
  logic             shifting;
  logic             drive_edge;
  logic             sample_edge;
  logic             last_edge;
  logic             load_go;
  logic [7:0]       load_byte;
  logic [NCS-1:0]   cs_dec;

  assign busy     = (state != ST_IDLE);
  assign shifting = (state == ST_SHIFT);
  assign clk_en   = shifting || (state == ST_END);
  assign tx_ready = (state == ST_LOAD) && !fill_r && tx_valid;
  assign load_go  = (state == ST_LOAD) && (fill_r || tx_valid);
  assign load_byte = fill_r ? FILL_BYTE : tx_data;

  // Leading edge samples in CPHA=0 and drives in CPHA=1.
  assign sample_edge = shifting && (cpha_r ? trail : lead);
  assign drive_edge  = shifting && (cpha_r ? lead : trail);
  assign last_edge   = shifting && trail && (edge_cnt == 4'd15);

  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NCS; i++) begin
      if (int'(cs_sel) == i) cs_dec[i] = 1'b0;
    end
  end

  spi_clkgen #(
    .DIV_W (DIV_W)
  ) u_clkgen (
    .clk   (clk),
    .reset (reset),
    .en    (clk_en),
    .div   (div_r),
    .lead  (lead),
    .trail (trail)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      bytes_left <= '0;
      div_r      <= '0;
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      hold_r     <= 1'b0;
      fill_r     <= 1'b0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      edge_cnt   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      done       <= 1'b0;
      sclk       <= 1'b0;
      mosi       <= 1'b1;
      cs_n       <= '1;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bytes_left <= len;
            div_r      <= div;
            cpol_r     <= cpol;
            cpha_r     <= cpha;
            hold_r     <= hold_cs;
            fill_r     <= fill;
            sclk       <= cpol;
            cs_n       <= cs_dec;
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          state <= (bytes_left == '0) ? ST_END : ST_LOAD;
        end
        ST_LOAD: begin
          if (load_go) begin
            edge_cnt <= '0;
            state    <= ST_SHIFT;
            // CPHA=0 presents bit 7 a full half-period ahead.
            if (cpha_r) begin
              tx_sh <= load_byte;
            end else begin
              mosi  <= load_byte[7];
              tx_sh <= {load_byte[6:0], 1'b1};
            end
          end
        end
        ST_SHIFT: begin
          if (lead || trail) begin
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 4'd1;
          end
          if (drive_edge) begin
            mosi  <= tx_sh[7];
            tx_sh <= {tx_sh[6:0], 1'b1};
          end
          if (sample_edge) begin
            rx_sh <= {rx_sh[5:0], miso};
            if (edge_cnt[3:1] == 3'd7) begin
              rx_data  <= {rx_sh, miso};
              rx_valid <= 1'b1;
            end
          end
          if (last_edge) begin
            bytes_left <= bytes_left - LEN_W'(1);
            state      <= (bytes_left == LEN_W'(1)) ? ST_END : ST_LOAD;
          end
        end
        ST_END: begin
          mosi <= 1'b1;
          sclk <= cpol_r;
          if (lead || trail) begin
            done  <= 1'b1;
            state <= ST_IDLE;
            if (!hold_r) cs_n <= '1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmc_spi_engine.sv
// Self-checking bench for mmc_spi_engine: loopback SPI with a
// transfer-level model checked every cycle plus literal checks.
module tb_mmc_spi_engine;

  localparam int NCS   = 2;
  localparam int DIV_W = 16;
  localparam int LEN_W = 10;
  localparam logic [NCS-1:0] ALL1 = '1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [DIV_W-1:0] div = '0;
  logic             cpol = 1'b0;
  logic             cpha = 1'b0;
  logic [0:0]       cs_sel = '0;
  logic             hold_cs = 1'b0;
  logic             fill = 1'b0;
  logic [7:0]       tx_data = '0;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             busy;
  logic             done;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic [NCS-1:0]   cs_n;

  always #5 clk = ~clk;
  assign miso = mosi;

  mmc_spi_engine #(
    .NCS   (NCS),
    .DIV_W (DIV_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .div      (div),
    .cpol     (cpol),
    .cpha     (cpha),
    .cs_sel   (cs_sel),
    .hold_cs  (hold_cs),
    .fill     (fill),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .done     (done),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .cs_n     (cs_n)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer model written by the driver, consumed by the monitor.
  bit             m_active = 1'b0;
  bit             in_reset = 1'b1;
  int             m_len, m_div;
  bit             m_cpol, m_cpha, m_fill, m_hold;
  logic [NCS-1:0] m_mask = ALL1;
  logic [NCS-1:0] m_idle_mask = ALL1;
  logic [7:0]     m_tx[$];
  logic [7:0]     m_rx[$];

  // Monitor-owned bookkeeping.
  int   cyc = 0;
  int   m_edges, m_txr, m_rxv, m_bit, m_last_edge, m_max_gap;
  logic prev_sclk = 1'b0;
  bit   mon_prev_active = 1'b0;

  always @(negedge clk) begin
    logic [7:0] b;
    int gap;
    cyc++;
    if (in_reset) begin
      prev_sclk = 1'b0;
      mon_prev_active = 1'b0;
    end else if (!m_active) begin
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_cs", cs_n, m_idle_mask);
      check("idle_sclk", sclk, prev_sclk);
      check("idle_mosi", mosi, 1);
      check("idle_rx_valid", rx_valid, 0);
      prev_sclk = sclk;
      mon_prev_active = 1'b0;
    end else begin
      if (!mon_prev_active) begin
        m_edges = 0; m_txr = 0; m_rxv = 0; m_bit = 0;
        m_max_gap = 0; m_last_edge = cyc;
        check("setup_sclk", sclk, m_cpol);
        prev_sclk = sclk;
      end else if (sclk !== prev_sclk) begin
        m_edges++;
        gap = cyc - m_last_edge;
        m_last_edge = cyc;
        if ((m_edges - 1) % 16 != 0) begin
          check("half_period", gap, m_div + 1);
        end else begin
          if (gap > m_max_gap) m_max_gap = gap;
          check("byte_gap_min", gap >= m_div + 2, 1);
        end
        if ((sclk != m_cpol) == !m_cpha) begin
          if (m_tx.size() == 0) begin
            check("extra_sample", 1, 0);
          end else begin
            b = m_tx[0];
            check("mosi_bit", mosi, b[7-m_bit]);
            m_bit++;
            if (m_bit == 8) begin
              m_bit = 0;
              void'(m_tx.pop_front());
            end
          end
        end
        prev_sclk = sclk;
      end
      mon_prev_active = 1'b1;
      if (rx_valid) begin
        m_rxv++;
        if (m_rx.size() == 0) check("extra_rx", 1, 0);
        else check("rx_data", rx_data, m_rx.pop_front());
      end
      if (tx_ready) begin
        m_txr++;
        check("tx_ready_valid", tx_valid, 1);
      end
      if (m_fill) check("fill_mosi", mosi, 1);
      if (done) begin
        check("done_busy", busy, 0);
        check("done_cs", cs_n, m_hold ? m_mask : ALL1);
        check("edge_count", m_edges, 16 * m_len);
        check("tx_count", m_txr, m_fill ? 0 : m_len);
        check("rx_count", m_rxv, m_len);
        check("end_sclk", sclk, m_cpol);
        check("end_mosi", mosi, 1);
        check("bits_left", m_tx.size(), 0);
      end else begin
        check("busy", busy, 1);
        check("active_cs", cs_n, m_mask);
      end
    end
  end

  function automatic logic [7:0] pat(input logic [7:0] base, input int i);
    return base ^ 8'(i * 60);
  endfunction

  task automatic xfer(input int n, input int dv, input bit pol,
                      input bit pha, input int sel, input bit hold,
                      input bit fl, input logic [7:0] base,
                      input int stall_idx, input int stall_cyc,
                      input int abort_at,
                      output int lat, output logic [NCS-1:0] cs_first);
    logic [7:0] d;
    bit got;
    int bound;
    lat = 0;
    m_len = n; m_div = dv; m_cpol = pol; m_cpha = pha;
    m_fill = fl; m_hold = hold;
    m_mask = ALL1;
    if (sel < NCS) m_mask[sel] = 1'b0;
    m_tx.delete();
    m_rx.delete();
    for (int i = 0; i < n; i++) begin
      d = fl ? 8'hFF : pat(base, i);
      m_tx.push_back(d);
      m_rx.push_back(d);
    end
    @(posedge clk) #1;
    len = LEN_W'(n); div = DIV_W'(dv); cpol = pol; cpha = pha;
    cs_sel = 1'(sel); hold_cs = hold; fill = fl; start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    m_active = 1'b1;
    cs_first = cs_n;
    // Config inputs wander mid-transfer; the engine must ignore them.
    div = DIV_W'(3); cpol = ~pol; cpha = ~pha;
    hold_cs = ~hold; fill = ~fl; cs_sel = ~cs_sel;
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      #1;
      reset = 1'b1; in_reset = 1'b1; m_active = 1'b0;
      m_idle_mask = ALL1; tx_valid = 1'b0;
      @(posedge clk) #1;
      reset = 1'b0;
      check("rst_cs", cs_n, ALL1);
      check("rst_sclk", sclk, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_mosi", mosi, 1);
      check("rst_rx_data", rx_data, 0);
      in_reset = 1'b0;
      return;
    end
    bound = 16 * (dv + 1) * 2 + stall_cyc + 100;
    if (!fl) begin
      for (int i = 0; i < n; i++) begin
        if (i == stall_idx) begin
          for (int k = 0; k < bound && m_rxv < i; k++) @(posedge clk) #1;
          check("stall_sync", m_rxv >= i, 1);
          repeat (stall_cyc) @(posedge clk);
          #1;
        end
        tx_data = pat(base, i);
        tx_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < bound && !got; k++) begin
          @(negedge clk);
          got = tx_ready;
        end
        check("tx_handshake", got, 1);
        @(posedge clk) #1;
        tx_valid = 1'b0;
      end
    end
    bound = n * (16 * (dv + 1) + 4) + dv + 60 + stall_cyc;
    got = 1'b0;
    for (int k = 1; k <= bound && !got; k++) begin
      @(posedge clk) #1;
      if (done) begin
        got = 1'b1;
        lat = k + 1;
      end
    end
    check("done_seen", got, 1);
    @(negedge clk);
    #1;
    m_idle_mask = (got && hold) ? m_mask : ALL1;
    m_active = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [NCS-1:0] csf;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_cs", cs_n, ALL1);
    check("reset_sclk", sclk, 0);
    check("reset_mosi", mosi, 1);
    check("reset_busy", busy, 0);
    check("reset_rx_data", rx_data, 0);
    in_reset = 1'b0;
    repeat (3) @(posedge clk);

    // Mode 0 loopback, one byte
    xfer(1, 0, 0, 0, 0, 0, 0, 8'hA5, -1, 0, 0, lat, csf);
    check("m0_rx_A5", rx_data, 8'hA5);
    // Modes 1..3 loopback
    xfer(1, 1, 0, 1, 0, 0, 0, 8'hA5, -1, 0, 0, lat, csf);
    check("m1_rx_A5", rx_data, 8'hA5);
    xfer(1, 1, 1, 0, 1, 0, 0, 8'hA5, -1, 0, 0, lat, csf);
    check("m2_rx_A5", rx_data, 8'hA5);
    check("m2_idle_sclk", sclk, 1);
    xfer(1, 2, 1, 1, 0, 0, 0, 8'hA5, -1, 0, 0, lat, csf);
    check("m3_rx_A5", rx_data, 8'hA5);

    // Fill, div=0: done 20 cycles after start, CS low next cycle
    xfer(1, 0, 0, 0, 0, 0, 1, 8'h00, -1, 0, 0, lat, csf);
    check("latency", lat, 20);
    check("cs_first", csf, 2'b10);
    check("fill_rx_FF", rx_data, 8'hFF);

    // Three bytes with a 20-cycle tx stall before byte 2
    xfer(3, 1, 0, 0, 0, 0, 0, 8'h3C, 1, 20, 0, lat, csf);
    check("stall_gap", m_max_gap >= 20, 1);
    check("stall_last_rx", rx_data, pat(8'h3C, 2));

    // Long fill on CS1 with slow clock
    xfer(10, 249, 0, 0, 1, 0, 1, 8'h00, -1, 0, 0, lat, csf);
    check("fill_cs1", csf, 2'b01);

    // Held CS then release with an empty transfer
    xfer(6, 2, 1, 1, 0, 1, 0, 8'h96, -1, 0, 0, lat, csf);
    check("hold_cs_low", cs_n, 2'b10);
    repeat (5) @(posedge clk);
    xfer(0, 1, 1, 1, 0, 0, 0, 8'h00, -1, 0, 0, lat, csf);
    check("release_cs", cs_n, 2'b11);

    // Reset mid-byte, then a fresh transfer
    xfer(2, 3, 0, 0, 1, 0, 1, 8'h00, -1, 0, 6, lat, csf);
    repeat (30) @(posedge clk);
    xfer(2, 0, 0, 0, 0, 0, 0, 8'h5A, -1, 0, 0, lat, csf);
    check("post_reset_rx", rx_data, pat(8'h5A, 1));

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
